// File: rtl/cpuif_arbiter.sv
// Two-master round-robin arbiter for the shared CSR bus, one outstanding slave transaction.
// Optional slave-ack watchdog enabled by defining CPUIF_ARB_TIMEOUT_EN.
package pkg_cpu_if;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              req;
    logic              req_is_wr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_biten;
  } cpu_if_o;

  typedef struct packed {
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              wr_ack;
  } cpu_if_i;
endpackage

module cpuif_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
`ifdef CPUIF_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  pkg_cpu_if::cpu_if_o m0_cpuif_o,
  output pkg_cpu_if::cpu_if_i m0_cpuif_i,
  input  pkg_cpu_if::cpu_if_o m1_cpuif_o,
  output pkg_cpu_if::cpu_if_i m1_cpuif_i,
  output pkg_cpu_if::cpu_if_o s_cpuif_o,
  input  pkg_cpu_if::cpu_if_i s_cpuif_i,
  output logic [1:0]          err_ovf,
  output logic                err_spur,
  output logic                err_tmo,
  input  logic                err_clr
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_WAIT} state_t;

  state_t                r_state;
  logic                  r_owner;
  logic                  r_rr_ptr;
  logic [1:0]            r_slot_vld;
  logic [ADDR_WIDTH-1:0] r_slot_addr  [2];
  logic [1:0]            r_slot_wr;
  logic [DATA_WIDTH-1:0] r_slot_wdata [2];
  logic [DATA_WIDTH-1:0] r_slot_biten [2];

  logic                  r_s_req;
  logic                  r_s_wr;
  logic [ADDR_WIDTH-1:0] r_s_addr;
  logic [DATA_WIDTH-1:0] r_s_wdata;
  logic [DATA_WIDTH-1:0] r_s_biten;

  logic [1:0]            r_rd_ack;
  logic [1:0]            r_wr_ack;
  logic [DATA_WIDTH-1:0] r_rd_data [2];
  logic [1:0]            r_err_ovf;
  logic                  r_err_spur;

  pkg_cpu_if::cpu_if_o   w_mreq [2];
  logic [1:0]            w_free;
  logic [1:0]            w_ovf;
  logic                  w_sel;
  logic                  w_s_ack;
  logic                  w_spur;
  logic                  w_tmo;

  assign w_mreq[0] = m0_cpuif_o;
  assign w_mreq[1] = m1_cpuif_o;
  assign w_s_ack   = s_cpuif_i.rd_ack | s_cpuif_i.wr_ack;
  assign w_spur    = (r_state == ST_IDLE) && w_s_ack;

  // r_rr_ptr names the master that wins the next tie; it only moves when a tie is resolved.
  always_comb begin
    w_free = '0;
    w_ovf  = '0;
    for (int m = 0; m < 2; m++) begin
      w_free[m] = (r_state == ST_GRANT) && (r_owner == m[0]);
      w_ovf[m]  = w_mreq[m].req && r_slot_vld[m] && !w_free[m];
    end
    w_sel = (&r_slot_vld) ? r_rr_ptr : r_slot_vld[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_slot_vld <= '0;
      r_slot_wr  <= '0;
      r_s_req    <= 1'b0;
      r_s_wr     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_s_biten  <= '0;
      r_rd_ack   <= '0;
      r_wr_ack   <= '0;
      r_err_ovf  <= '0;
      r_err_spur <= 1'b0;
      for (int m = 0; m < 2; m++) begin
        r_slot_addr[m]  <= '0;
        r_slot_wdata[m] <= '0;
        r_slot_biten[m] <= '0;
        r_rd_data[m]    <= '0;
      end
    end else begin
      r_rd_ack <= '0;
      r_wr_ack <= '0;

      for (int m = 0; m < 2; m++) begin
        if (w_mreq[m].req && (!r_slot_vld[m] || w_free[m])) begin
          r_slot_vld[m]   <= 1'b1;
          r_slot_addr[m]  <= w_mreq[m].addr;
          r_slot_wr[m]    <= w_mreq[m].req_is_wr;
          r_slot_wdata[m] <= w_mreq[m].wr_data;
          r_slot_biten[m] <= w_mreq[m].wr_biten;
        end else if (w_free[m]) begin
          r_slot_vld[m]   <= 1'b0;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (|r_slot_vld) begin
            r_state   <= ST_GRANT;
            r_owner   <= w_sel;
            r_s_req   <= 1'b1;
            r_s_wr    <= r_slot_wr[w_sel];
            r_s_addr  <= r_slot_addr[w_sel];
            r_s_wdata <= r_slot_wdata[w_sel];
            r_s_biten <= r_slot_biten[w_sel];
            if (&r_slot_vld) r_rr_ptr <= ~w_sel;
          end
        end
        ST_GRANT: begin
          r_s_req <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_s_ack) begin
            r_rd_ack[r_owner] <= s_cpuif_i.rd_ack;
            r_wr_ack[r_owner] <= s_cpuif_i.wr_ack;
            if (s_cpuif_i.rd_ack) r_rd_data[r_owner] <= s_cpuif_i.rd_data;
            r_state <= ST_IDLE;
          end else if (w_tmo) begin
            if (r_s_wr) begin
              r_wr_ack[r_owner]  <= 1'b1;
            end else begin
              r_rd_ack[r_owner]  <= 1'b1;
              r_rd_data[r_owner] <= '1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      r_err_ovf  <= (r_err_ovf & ~{2{err_clr}}) | w_ovf;
      r_err_spur <= (r_err_spur & ~err_clr) | w_spur;
    end
  end

`ifdef CPUIF_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err_tmo;

  // Counter is loaded during GRANT so it reads zero on the last permitted WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      if (r_state == ST_GRANT)
        r_tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
      else if ((r_state == ST_WAIT) && (r_tmo_cnt != '0))
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      r_err_tmo <= (r_err_tmo & ~err_clr) | w_tmo;
    end
  end

  assign w_tmo   = (r_state == ST_WAIT) && (r_tmo_cnt == '0) && !w_s_ack;
  assign err_tmo = r_err_tmo;
`else
  assign w_tmo   = 1'b0;
  assign err_tmo = 1'b0;
`endif

  assign s_cpuif_o  = '{addr: r_s_addr, req: r_s_req, req_is_wr: r_s_wr,
                        wr_data: r_s_wdata, wr_biten: r_s_biten};
  assign m0_cpuif_i = '{rd_ack: r_rd_ack[0], rd_data: r_rd_data[0], wr_ack: r_wr_ack[0]};
  assign m1_cpuif_i = '{rd_ack: r_rd_ack[1], rd_data: r_rd_data[1], wr_ack: r_wr_ack[1]};
  assign err_ovf    = r_err_ovf;
  assign err_spur   = r_err_spur;

endmodule

// File: tb/tb_cpuif_arbiter.sv
// Directed self-checking bench for cpuif_arbiter; build with CPUIF_ARB_TIMEOUT_EN to exercise the watchdog.
module tb_cpuif_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic err_clr;
  logic [1:0] err_ovf;
  logic err_spur, err_tmo;
  pkg_cpu_if::cpu_if_o m0_o, m1_o, s_o;
  pkg_cpu_if::cpu_if_i m0_i, m1_i, s_i;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpuif_arbiter #(
    .ADDR_WIDTH(17),
    .DATA_WIDTH(16)
`ifdef CPUIF_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cpuif_o(m0_o), .m0_cpuif_i(m0_i),
    .m1_cpuif_o(m1_o), .m1_cpuif_i(m1_i),
    .s_cpuif_o(s_o), .s_cpuif_i(s_i),
    .err_ovf(err_ovf), .err_spur(err_spur), .err_tmo(err_tmo), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic wr, input logic [16:0] a,
                         input logic [15:0] d, input logic [15:0] be);
    pkg_cpu_if::cpu_if_o t;
    t = '{addr: a, req: 1'b1, req_is_wr: wr, wr_data: d, wr_biten: be};
    if (m == 0) m0_o = t; else m1_o = t;
  endtask

  task automatic clr_req();
    m0_o.req = 1'b0;
    m1_o.req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; err_clr = 1'b0;
    m0_o = '0; m1_o = '0; s_i = '0;
    tick(); tick(); tick();
    checks++; if (s_o !== '0) begin errors++; $display("FAIL rst_s_o got %h exp 0", s_o); end
    checks++; if (m0_i !== '0 || m1_i !== '0) begin errors++; $display("FAIL rst_m_i got %h %h exp 0", m0_i, m1_i); end
    checks++; if ({err_ovf, err_spur, err_tmo} !== 4'b0) begin errors++; $display("FAIL rst_err got %b exp 0", {err_ovf, err_spur, err_tmo}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    set_req(0, 1'b1, 17'h00010, 16'hBEEF, 16'h00FF);
    tick(); clr_req();
    checks++; if (s_o.req !== 1'b0) begin errors++; $display("FAIL wr_req_n1 got %b exp 0", s_o.req); end
    tick();
    checks++; if (s_o.req !== 1'b1 || s_o.addr !== 17'h10 || s_o.req_is_wr !== 1'b1)
      begin errors++; $display("FAIL wr_req_n2 got req=%b addr=%h wr=%b exp 1 10 1", s_o.req, s_o.addr, s_o.req_is_wr); end
    checks++; if (s_o.wr_data !== 16'hBEEF || s_o.wr_biten !== 16'h00FF)
      begin errors++; $display("FAIL wr_data got %h/%h exp BEEF/00FF", s_o.wr_data, s_o.wr_biten); end
    tick();
    checks++; if (s_o.req !== 1'b0 || s_o.addr !== 17'h10) begin errors++; $display("FAIL wr_hold got req=%b addr=%h exp 0 10", s_o.req, s_o.addr); end
    s_i.wr_ack = 1'b1;
    tick(); s_i.wr_ack = 1'b0;
    checks++; if (m0_i.wr_ack !== 1'b1 || m0_i.rd_ack !== 1'b0) begin errors++; $display("FAIL wr_m0_ack got %b/%b exp 1/0", m0_i.wr_ack, m0_i.rd_ack); end
    checks++; if (m1_i !== '0) begin errors++; $display("FAIL wr_m1_quiet got %h exp 0", m1_i); end
    tick();
    checks++; if (m0_i.wr_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b exp 0", m0_i.wr_ack); end
  endtask

  task automatic test_round_robin();
    int exp_m [4] = '{0, 1, 1, 0};
    for (int p = 0; p < 2; p++) begin
      set_req(0, 1'b1, 17'h00100, 16'h1111, 16'hFFFF);
      set_req(1, 1'b1, 17'h00200, 16'h2222, 16'hFFFF);
      tick(); clr_req();
      for (int g = 0; g < 2; g++) begin
        int em;
        logic [16:0] ea;
        em = exp_m[p*2+g];
        ea = (em == 0) ? 17'h00100 : 17'h00200;
        tick();
        checks++; if (s_o.req !== 1'b1 || s_o.addr !== ea)
          begin errors++; $display("FAIL rr_grant%0d got req=%b addr=%h exp 1 %h", p*2+g, s_o.req, s_o.addr, ea); end
        tick();
        s_i.wr_ack = 1'b1;
        tick(); s_i.wr_ack = 1'b0;
        checks++; if ({m1_i.wr_ack, m0_i.wr_ack} !== ((em == 0) ? 2'b01 : 2'b10))
          begin errors++; $display("FAIL rr_ack%0d got %b%b exp master %0d", p*2+g, m1_i.wr_ack, m0_i.wr_ack, em); end
      end
    end
  endtask

  task automatic test_read();
    set_req(0, 1'b0, 17'h00041, 16'h0, 16'h0);
    tick(); clr_req();
    tick();
    tick();
    s_i.rd_ack = 1'b1; s_i.rd_data = 16'h5A5A;
    tick(); s_i.rd_ack = 1'b0; s_i.rd_data = 16'hDEAD;
    checks++; if (m0_i.rd_ack !== 1'b1 || m0_i.rd_data !== 16'h5A5A)
      begin errors++; $display("FAIL rd_m0 got %b %h exp 1 5A5A", m0_i.rd_ack, m0_i.rd_data); end
    set_req(1, 1'b0, 17'h00042, 16'h0, 16'h0);
    tick(); clr_req();
    tick();
    checks++; if (s_o.req !== 1'b1 || s_o.addr !== 17'h42 || s_o.req_is_wr !== 1'b0)
      begin errors++; $display("FAIL rd_req got req=%b addr=%h wr=%b exp 1 42 0", s_o.req, s_o.addr, s_o.req_is_wr); end
    tick();
    s_i.rd_ack = 1'b1; s_i.rd_data = 16'h1234;
    tick(); s_i.rd_ack = 1'b0; s_i.rd_data = 16'hDEAD;
    checks++; if (m1_i.rd_ack !== 1'b1 || m1_i.rd_data !== 16'h1234)
      begin errors++; $display("FAIL rd_m1 got %b %h exp 1 1234", m1_i.rd_ack, m1_i.rd_data); end
    checks++; if (m0_i.rd_ack !== 1'b0 || m0_i.rd_data !== 16'h5A5A)
      begin errors++; $display("FAIL rd_m0_keep got %b %h exp 0 5A5A", m0_i.rd_ack, m0_i.rd_data); end
    tick();
    checks++; if (m1_i.rd_ack !== 1'b0 || m1_i.rd_data !== 16'h1234)
      begin errors++; $display("FAIL rd_m1_hold got %b %h exp 0 1234", m1_i.rd_ack, m1_i.rd_data); end
  endtask

  task automatic test_overflow();
    set_req(0, 1'b1, 17'h00300, 16'h0300, 16'hFFFF);
    tick(); clr_req();
    tick();
    tick();
    set_req(0, 1'b1, 17'h00301, 16'h0301, 16'hFFFF);
    tick(); clr_req();
    checks++; if (err_ovf !== 2'b00) begin errors++; $display("FAIL ovf_slot_ok got %b exp 00", err_ovf); end
    set_req(0, 1'b1, 17'h00302, 16'h0302, 16'hFFFF);
    tick(); clr_req();
    checks++; if (err_ovf !== 2'b01) begin errors++; $display("FAIL ovf_set got %b exp 01", err_ovf); end
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    checks++; if (err_ovf !== 2'b00) begin errors++; $display("FAIL ovf_clr got %b exp 00", err_ovf); end
    err_clr = 1'b1;
    set_req(0, 1'b1, 17'h00303, 16'h0303, 16'hFFFF);
    tick(); clr_req(); err_clr = 1'b0;
    checks++; if (err_ovf !== 2'b01) begin errors++; $display("FAIL ovf_set_wins got %b exp 01", err_ovf); end
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    s_i.wr_ack = 1'b1;
    tick(); s_i.wr_ack = 1'b0;
    checks++; if (m0_i.wr_ack !== 1'b1) begin errors++; $display("FAIL ovf_ack_a got %b exp 1", m0_i.wr_ack); end
    tick();
    checks++; if (s_o.req !== 1'b1 || s_o.addr !== 17'h301) begin errors++; $display("FAIL ovf_grant_b got req=%b addr=%h exp 1 301", s_o.req, s_o.addr); end
    set_req(0, 1'b1, 17'h00304, 16'h0304, 16'hFFFF);
    tick(); clr_req();
    checks++; if (err_ovf !== 2'b00) begin errors++; $display("FAIL ovf_freed_accept got %b exp 00", err_ovf); end
    s_i.wr_ack = 1'b1;
    tick(); s_i.wr_ack = 1'b0;
    tick();
    checks++; if (s_o.req !== 1'b1 || s_o.addr !== 17'h304) begin errors++; $display("FAIL ovf_grant_e got req=%b addr=%h exp 1 304", s_o.req, s_o.addr); end
    s_i.wr_ack = 1'b1;
    tick(); s_i.wr_ack = 1'b0;
    checks++; if (m0_i.wr_ack !== 1'b0 || err_spur !== 1'b0) begin errors++; $display("FAIL grant_ack_ignored got ack=%b spur=%b exp 0 0", m0_i.wr_ack, err_spur); end
    tick();
    checks++; if (m0_i.wr_ack !== 1'b0) begin errors++; $display("FAIL grant_ack_wait got %b exp 0", m0_i.wr_ack); end
    s_i.wr_ack = 1'b1;
    tick(); s_i.wr_ack = 1'b0;
    checks++; if (m0_i.wr_ack !== 1'b1) begin errors++; $display("FAIL ovf_ack_e got %b exp 1", m0_i.wr_ack); end
    tick();
  endtask

  task automatic test_no_ack();
    set_req(0, 1'b0, 17'h00400, 16'h0, 16'h0);
    tick(); clr_req();
    tick();
    checks++; if (s_o.req !== 1'b1 || s_o.addr !== 17'h400) begin errors++; $display("FAIL noack_grant got req=%b addr=%h exp 1 400", s_o.req, s_o.addr); end
`ifdef CPUIF_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (m0_i.rd_ack !== 1'b0) begin errors++; $display("FAIL tmo_early%0d got %b exp 0", i, m0_i.rd_ack); end
    end
    tick();
    checks++; if (m0_i.rd_ack !== 1'b1 || m0_i.rd_data !== 16'hFFFF || err_tmo !== 1'b1)
      begin errors++; $display("FAIL tmo_fire got ack=%b data=%h err=%b exp 1 FFFF 1", m0_i.rd_ack, m0_i.rd_data, err_tmo); end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (m0_i.rd_ack !== 1'b0 || s_o.req !== 1'b0 || s_o.addr !== 17'h400 || err_tmo !== 1'b0)
        begin errors++; $display("FAIL noack_hold%0d got ack=%b req=%b addr=%h tmo=%b exp 0 0 400 0", i, m0_i.rd_ack, s_o.req, s_o.addr, err_tmo); end
    end
`endif
  endtask

  task automatic test_reset_mid();
`ifdef CPUIF_ARB_TIMEOUT_EN
    set_req(0, 1'b1, 17'h00500, 16'h0500, 16'hFFFF);
    tick(); clr_req();
    tick();
    tick();
`endif
    reset = 1'b1;
    tick(); reset = 1'b0;
    checks++; if (s_o !== '0 || m0_i !== '0) begin errors++; $display("FAIL rstmid_clear got s=%h m0=%h exp 0", s_o, m0_i); end
    s_i.wr_ack = 1'b1;
    tick(); s_i.wr_ack = 1'b0;
    checks++; if (m0_i.wr_ack !== 1'b0 || m1_i.wr_ack !== 1'b0 || s_o.req !== 1'b0)
      begin errors++; $display("FAIL rstmid_noack got m0=%b m1=%b req=%b exp 0 0 0", m0_i.wr_ack, m1_i.wr_ack, s_o.req); end
    checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL rstmid_spur got %b exp 1", err_spur); end
    tick();
    checks++; if (s_o.req !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b exp 0", s_o.req); end
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    checks++; if (err_spur !== 1'b0) begin errors++; $display("FAIL spur_clr got %b exp 0", err_spur); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_read();
    test_overflow();
    test_no_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
